multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/multicycle_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared opcode constants, ALU operation encodings and controller state type.
// Pure declarations: no logic, no latency.
// No flow control of its own; users decide how these values are sequenced.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle RV-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing, outputs decoded from state.
// Latency (mem_ready high): beq 3, R 4, store 4, load 5 cycles; outputs are combinational.
// Backpressure: FETCH and MEM hold while mem_ready is low. MC_ILLEGAL_TRAP_EN: trap to HALT on bad opcode.
module multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       pc_src,
  output logic       retire,
  output logic       illegal
);

  state_t state;

  logic is_r;
  logic is_ld;
  logic is_st;
  logic is_br;
  logic is_sup;

  assign is_r   = (opcode == OP_RTYPE);
  assign is_ld  = (opcode == OP_LOAD);
  assign is_st  = (opcode == OP_STORE);
  assign is_br  = (opcode == OP_BRANCH);
  assign is_sup = is_r | is_ld | is_st | is_br;

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // State sequencing (and sticky illegal flag when trapping is enabled)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FETCH: if (mem_ready) state <= ST_DECODE;
        ST_DECODE: begin
          if (is_sup) begin
            state <= ST_EXEC;
          end else begin
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_q <= 1'b1;
            state     <= ST_HALT;
`else
            state     <= ST_FETCH;
`endif
          end
        end
        ST_EXEC: begin
          if (is_r)               state <= ST_WB;
          else if (is_ld || is_st) state <= ST_MEM;
          else                    state <= ST_FETCH;
        end
        ST_MEM: if (mem_ready) state <= is_st ? ST_FETCH : ST_WB;
        ST_WB:   state <= ST_FETCH;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Control outputs decoded from state and opcode; all forced low while in reset
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    pc_src     = 1'b0;
    retire     = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      ST_DECODE: begin
`ifndef MC_ILLEGAL_TRAP_EN
        retire = ~is_sup;
`endif
      end
      ST_EXEC: begin
        if (is_r) begin
          alu_op = ALU_FUNCT;
        end else if (is_ld || is_st) begin
          alu_src = 1'b1;
        end else if (is_br) begin
          alu_op   = ALU_SUB;
          pc_write = zero;
          pc_src   = 1'b1;
          retire   = 1'b1;
        end
      end
      ST_MEM: begin
        mem_read  = is_ld;
        mem_write = is_st;
        retire    = is_st & mem_ready;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ld;
        retire     = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      pc_src     = 1'b0;
      retire     = 1'b0;
    end
  end

endmodule
